// File: rtl/io_pkg.sv
// Shared types and defaults for the io_unit block.
// Holds the default RX FIFO depth and the input-FSM state encoding.
package io_pkg;

    localparam int RX_DEPTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } in_state_t;

endpackage

// File: rtl/io_if.sv
// Pipeline/UART side bundle of io_unit.
// master: pipeline + UART driver side; slave: io_unit itself.
interface io_if;

    logic        out_issued;
    logic [7:0]  out_data;
    logic        in_issued;
    logic [31:0] in_data;
    logic        in_valid;
    logic        io_stall;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_overflow;

    modport master (
        output out_issued, out_data, in_issued,
        output tx_ready, rx_data, rx_valid,
        input  in_data, in_valid, io_stall,
        input  tx_data, tx_valid, rx_overflow
    );

    modport slave (
        input  out_issued, out_data, in_issued,
        input  tx_ready, rx_data, rx_valid,
        output in_data, in_valid, io_stall,
        output tx_data, tx_valid, rx_overflow
    );

endinterface

// File: rtl/io_rx_fifo.sv
// Byte FIFO for received UART data with a sticky drop flag.
// Ports: push/push_data in, pop in, pop_data/full/empty/overflow out.
module io_rx_fifo
    import io_pkg::*;
#(
    parameter int DEPTH = RX_DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    // Extra pointer bit separates full from empty when indices match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A pop frees the slot, so a full FIFO can still take a byte.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr_q[AW-1:0]];
    assign overflow = overflow_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !do_push) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/io_unit.sv
// Execute-stage IO unit: cin_int word assembly from the RX FIFO, out byte TX.
// Ports: clk, rstn, io (io_if.slave) carrying pipeline and UART signals.
module io_unit
    import io_pkg::*;
#(
    parameter int RX_DEPTH = RX_DEPTH_DEFAULT
) (
    input  logic clk,
    input  logic rstn,
    io_if.slave  io
);

    in_state_t   state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [31:0] in_data_q, in_data_d;
    logic        in_valid_q, in_valid_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;

    logic        fifo_pop;
    logic [7:0]  fifo_data;
    logic        fifo_full;
    logic        fifo_empty;
    logic        tx_accept;
    logic        in_stall;

    io_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (io.rx_valid),
        .push_data (io.rx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (io.rx_overflow)
    );

    // A cin_int in the same cycle wins; the out waits behind the stall.
    assign tx_accept = io.out_issued && !io.in_issued &&
                       (!tx_valid_q || io.tx_ready);

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        in_data_d  = in_data_q;
        in_valid_d = 1'b0;
        fifo_pop   = 1'b0;
        in_stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (io.in_issued) begin
                    in_stall = 1'b1;
                    state_d  = COLLECT;
                    k_d      = 2'd0;
                end
            end
            COLLECT: begin
                in_stall = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    in_data_d[{k_q, 3'b000} +: 8] = fifo_data;
                    k_d = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        state_d    = DONE;
                        in_valid_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (tx_accept) begin
            tx_valid_d = 1'b1;
            tx_data_d  = io.out_data;
        end else if (io.tx_ready) begin
            tx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            k_q        <= 2'd0;
            in_data_q  <= '0;
            in_valid_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            in_data_q  <= in_data_d;
            in_valid_q <= in_valid_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Gated by rstn so the pipeline is never held while in reset.
    assign io.io_stall = rstn &&
                         (in_stall || (io.out_issued && !tx_accept));
    assign io.in_data  = in_data_q;
    assign io.in_valid = in_valid_q;
    assign io.tx_data  = tx_data_q;
    assign io.tx_valid = tx_valid_q;

endmodule

// File: doc/io_unit.md
IO_UNIT -- requirements
Module: io_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rstn  in  1  async active-low reset.
REQ-002 SHALL have the following ports:
- out_issued  in  1  decoded `out` instruction in execute.
- out_data  in  8  byte to transmit (rs1[7:0]).
- in_issued  in  1  decoded `cin_int` instruction in execute.
- in_data  out  32  assembled input word.
- in_valid  out  1  one-cycle pulse; in_data is valid for the writeback of the cin_int.
- io_stall  out  1  holds the pipeline.
- tx_data  out  8  byte to the UART transmitter.
- tx_valid  out  1  byte offered to the UART.
- tx_ready  in  1  UART accepts the byte.
- rx_data  in  8  byte from the UART receiver.
- rx_valid  in  1  one-cycle pulse; there is no backpressure on this path.
- rx_overflow  out  1  sticky flag: a received byte was dropped.
REQ-003 SHALL have one parameter, RX_DEPTH (default 16, power of two): the RX FIFO depth in bytes.

Function
REQ-004 RX FIFO SHALL push rx_data when rx_valid=1 and it is not full.
REQ-005 When full and not popping, the RX FIFO SHALL drop the byte and set rx_overflow=1 until reset.
REQ-006 On a simultaneous push and pop:
- When full, both SHALL occur and the count SHALL be unchanged.
- When empty, only the push SHALL occur.
REQ-007 Pointers SHALL be log2(RX_DEPTH)+1 bits and wrap modulo 2*RX_DEPTH; full/empty SHALL be decoded from the MSB-difference.
REQ-008 The input FSM SHALL have the states IDLE, COLLECT and DONE, plus a 2-bit byte counter k.
REQ-009 IDLE -> COLLECT SHALL occur on in_issued=1; k SHALL be cleared to 0.
REQ-010 In COLLECT, each cycle with the FIFO non-empty SHALL:
- pop one byte into in_data[8k+7:8k];
- increment k.
REQ-011 The byte order SHALL be little-endian.
REQ-012 The FSM SHALL move COLLECT -> DONE after the pop at k=3; an empty FIFO SHALL hold COLLECT indefinitely.
REQ-013 DONE SHALL last exactly one cycle:
- in_valid=1;
- then -> IDLE.
REQ-014 in_issued SHALL be ignored outside IDLE; the held instruction SHALL NOT retrigger in DONE.
REQ-015 io_stall SHALL be 1 combinationally:
- in the IDLE cycle in which in_issued=1;
- throughout COLLECT.
REQ-016 io_stall SHALL be 0 in DONE.
REQ-017 Minimum cin_int latency, with a FIFO of at least 4 bytes: in_issued at cycle 0 -> pops on cycles 1-4 -> in_valid on cycle 5.
REQ-018 in_data SHALL hold its value until the next COLLECT writes it.
REQ-019 The TX path SHALL use a one-byte holding register; tx_valid=1 while the register is occupied.
REQ-020 out_issued SHALL be accepted when tx_valid=0, or when tx_valid=1 and tx_ready=1 in the same cycle.
REQ-021 On acceptance, out_data SHALL be latched and tx_valid=1 from the next cycle.
REQ-022 The TX path SHALL add io_stall = out_issued and not accepted, ORed with REQ-015.
REQ-023 tx_valid SHALL clear after a tx_ready handshake unless a new byte is accepted in the same cycle.
REQ-024 tx_data SHALL be stable while tx_valid=1 and tx_ready=0.
REQ-025 out_issued and in_issued SHALL NOT both be 1; if they are, in_issued SHALL be processed and out_issued SHALL be stalled.

Reset
REQ-026 rstn=0 SHALL asynchronously force:
- FSM=IDLE, k=0;
- FIFO empty;
- tx_valid=0, tx_data=0;
- in_data=0, in_valid=0;
- rx_overflow=0.
REQ-027 io_stall SHALL be 0 during reset.
REQ-028 A reset during COLLECT SHALL discard the partial word and the FIFO contents.
REQ-029 A byte arriving in the cycle reset deasserts SHALL be pushed normally.

Structure
REQ-030 A shared package io_pkg SHALL hold:
- RX_DEPTH_DEFAULT;
- the in_state_t enum (IDLE, COLLECT, DONE).
REQ-031 The RX FIFO SHALL be the sub-module io_rx_fifo, with push, pop, full, empty and overflow-flag outputs.
REQ-032 The FSM and TX register SHALL live in io_unit.

Verification
REQ-033 Push 0x78, 0x56, 0x34, 0x12, then pulse in_issued -> io_stall=1 for 5 cycles; in_valid on cycle 5; in_data=0x12345678.
REQ-034 in_issued with the FIFO empty, then bytes 0xEF, 0xBE, 0xAD, 0xDE arriving 3 cycles apart -> stall holds throughout; in_data=0xDEADBEEF; exactly one in_valid pulse.
REQ-035 Push 17 bytes with no pop at RX_DEPTH=16 -> rx_overflow=1, the 17th byte is lost, and a subsequent cin_int returns bytes 1-4.
REQ-036 out_issued with out_data=0x41 and tx_ready held 0 for 3 cycles, with a second out (0x42) following:
- tx_data=0x41 stable throughout;
- the second out is stalled until the handshake;
- tx_data=0x42 in the next cycle.
REQ-037 FIFO full with rx_valid and a pop in the same cycle -> count stays 16 and rx_overflow stays 0.
REQ-038 Reset asserted in COLLECT at k=2 -> all REQ-026 values; the next cin_int starts at k=0 with an empty FIFO.
